// File: rtl/hps_program_loader.sv
// hps_program_loader
// Fabric-side receiver for the HPS boot-loader PIO channel. Reassembles
// toggle-qualified 10-bit halves into 20-bit words, writes them to the
// soft-core program RAM at consecutive addresses and holds the soft core
// in reset while a load session is in progress.
module hps_program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              boot_loader_i,
    input  logic [10:0]       instruction_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [19:0]       mem_wdata_o,
    output logic              cpu_reset_n_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [1:0]        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // Registered state
    state_t            state_r;
    logic              boot_q_r;
    logic              boot_prev_r;
    logic [10:0]       in_q_r;
    logic              tog_prev_r;
    logic              half_r;
    logic [9:0]        lo_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   count_r;
    logic [1:0]        err_r;
    logic              we_r;
    logic [ADDR_W-1:0] maddr_r;
    logic [19:0]       wdata_r;
    logic              cpu_rst_n_r;
    logic              done_r;

    // Next-state values
    state_t            state_s;
    logic              half_s;
    logic [9:0]        lo_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W:0]   count_s;
    logic [1:0]        err_s;
    logic              we_s;
    logic [ADDR_W-1:0] maddr_s;
    logic [19:0]       wdata_s;
    logic              cpu_rst_n_s;
    logic              done_s;

    // Decoded conditions from the registered inputs
    logic              event_s;
    logic              rise_s;
    logic              full_s;

    assign event_s = (in_q_r[10] != tog_prev_r);
    assign rise_s  = boot_q_r & ~boot_prev_r;
    // The count reaches 2^ADDR_W exactly when its top bit sets.
    assign full_s  = count_r[ADDR_W];

    // Next-state and output decode for the load sequencer
    always_comb begin
        state_s     = state_r;
        half_s      = half_r;
        lo_s        = lo_r;
        addr_s      = addr_r;
        count_s     = count_r;
        err_s       = err_r;
        we_s        = 1'b0;
        maddr_s     = maddr_r;
        wdata_s     = wdata_r;
        cpu_rst_n_s = cpu_rst_n_r;
        done_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Toggles seen here are stale; tog_prev tracks them anyway.
                if (rise_s) begin
                    state_s     = ST_LOAD;
                    addr_s      = ADDR_ZERO;
                    count_s     = CNT_ZERO;
                    err_s       = 2'b00;
                    half_s      = 1'b0;
                    cpu_rst_n_s = 1'b0;
                end else begin
                    cpu_rst_n_s = 1'b1;
                end
            end

            ST_LOAD: begin
                cpu_rst_n_s = 1'b0;
                // A toggle coincident with the boot fall is still honoured.
                if (event_s) begin
                    if (!half_r) begin
                        lo_s   = in_q_r[9:0];
                        half_s = 1'b1;
                    end else if (!full_s) begin
                        wdata_s = {in_q_r[9:0], lo_r};
                        maddr_s = addr_r;
                        we_s    = 1'b1;
                        addr_s  = addr_r + ADDR_ONE;
                        count_s = count_r + CNT_ONE;
                        half_s  = 1'b0;
                    end else begin
                        // RAM full: drop the word, keep the RAM port untouched.
                        err_s[1] = 1'b1;
                        half_s   = 1'b0;
                    end
                end else begin
                    half_s = half_r;
                end
                if (!boot_q_r) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_LOAD;
                end
            end

            ST_FINISH: begin
                // Core stays in reset this cycle; IDLE releases it next.
                cpu_rst_n_s = 1'b0;
                err_s[0]    = half_r;
                done_s      = 1'b1;
                state_s     = ST_IDLE;
            end

            default: begin
                cpu_rst_n_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State, input capture and output registers with synchronous reset
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_r     <= ST_IDLE;
            boot_q_r    <= 1'b0;
            boot_prev_r <= 1'b0;
            in_q_r      <= 11'd0;
            tog_prev_r  <= 1'b0;
            half_r      <= 1'b0;
            lo_r        <= 10'd0;
            addr_r      <= ADDR_ZERO;
            count_r     <= CNT_ZERO;
            err_r       <= 2'b00;
            we_r        <= 1'b0;
            maddr_r     <= ADDR_ZERO;
            wdata_r     <= 20'd0;
            cpu_rst_n_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            boot_q_r    <= boot_loader_i;
            boot_prev_r <= boot_q_r;
            in_q_r      <= instruction_i;
            tog_prev_r  <= in_q_r[10];
            half_r      <= half_s;
            lo_r        <= lo_s;
            addr_r      <= addr_s;
            count_r     <= count_s;
            err_r       <= err_s;
            we_r        <= we_s;
            maddr_r     <= maddr_s;
            wdata_r     <= wdata_s;
            cpu_rst_n_r <= cpu_rst_n_s;
            done_r      <= done_s;
        end
    end

    assign mem_we_o      = we_r;
    assign mem_addr_o    = maddr_r;
    assign mem_wdata_o   = wdata_r;
    assign cpu_reset_n_o = cpu_rst_n_r;
    assign load_done_o   = done_r;
    assign word_count_o  = count_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_hps_program_loader.sv
// Testbench for hps_program_loader: scoreboard of expected RAM writes
// (address, data, arrival cycle) filled by the stimulus driver and drained
// by a write monitor; session-end results checked after each load.
module tb_hps_program_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          boot;
    logic [10:0]   instr;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [19:0]   mem_wdata;
    logic          cpu_reset_n;
    logic          load_done;
    logic [AW:0]   word_count;
    logic [1:0]    err;

    hps_program_loader #(.ADDR_W(AW)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .boot_loader_i (boot),
        .instruction_i (instr),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .cpu_reset_n_o (cpu_reset_n),
        .load_done_o   (load_done),
        .word_count_o  (word_count),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Cycle counter advanced on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [19:0]   data;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;

    // Reference model of the loader session
    bit            tog;
    bit            m_active;
    bit            m_half;
    logic [9:0]    m_lo;
    logic [AW:0]   m_cnt;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_err;
    logic [19:0]   last_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: each RAM write must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                mon_w = exp_q.pop_front();
                check_eq("wr_addr", {30'd0, mem_addr}, {30'd0, mon_w.addr});
                check_eq("wr_data", {12'd0, mem_wdata}, {12'd0, mon_w.data});
                check_eq("wr_latency", cyc, mon_w.cyc);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Present one half now (caller is at a negedge) and update the model.
    task automatic drive_half(input logic [9:0] v);
        tog   = ~tog;
        instr = {tog, v};
        if (m_active) begin
            if (!m_half) begin
                m_lo   = v;
                m_half = 1'b1;
            end else begin
                if (m_cnt < (1 << AW)) begin
                    exp_q.push_back('{m_addr, {v, m_lo}, cyc + 2});
                    last_data = {v, m_lo};
                    m_addr    = m_addr + 1'b1;
                    m_cnt     = m_cnt + 1'b1;
                end else begin
                    m_err[1] = 1'b1;
                end
                m_half = 1'b0;
            end
        end
    endtask

    task automatic send_half(input logic [9:0] v);
        @(negedge clk);
        drive_half(v);
    endtask

    task automatic send_word(input logic [9:0] lo, input logic [9:0] hi);
        send_half(lo);
        send_half(hi);
        idle(1);
    endtask

    task automatic start_session(input bit coincident_tog);
        @(negedge clk);
        boot = 1'b1;
        if (coincident_tog) begin
            tog       = ~tog;
            instr[10] = tog;
        end
        m_active = 1'b1;
        m_half   = 1'b0;
        m_cnt    = '0;
        m_addr   = '0;
        m_err    = 2'b00;
        idle(2);
        check_eq("cpu_rst_in_load", {31'd0, cpu_reset_n}, 32'd0);
    endtask

    task automatic end_session(input bit with_hi, input logic [9:0] hi);
        int c0;
        bit found;
        @(negedge clk);
        boot = 1'b0;
        if (with_hi) drive_half(hi);
        c0    = cyc;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (load_done) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("done_seen", {31'd0, found}, 32'd1);
        check_eq("done_time", cyc, c0 + 3);
        check_eq("cpu_rst_at_done", {31'd0, cpu_reset_n}, 32'd0);
        check_eq("word_count", {29'd0, word_count}, {29'd0, m_cnt});
        check_eq("err", {30'd0, err}, {30'd0, m_err[1], m_half});
        @(negedge clk);
        check_eq("done_pulse_width", {31'd0, load_done}, 32'd0);
        check_eq("cpu_release", {31'd0, cpu_reset_n}, 32'd1);
        m_active = 1'b0;
    endtask

    task automatic check_reset_values();
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_addr", {30'd0, mem_addr}, 32'd0);
        check_eq("rst_wdata", {12'd0, mem_wdata}, 32'd0);
        check_eq("rst_cpu", {31'd0, cpu_reset_n}, 32'd0);
        check_eq("rst_done", {31'd0, load_done}, 32'd0);
        check_eq("rst_count", {29'd0, word_count}, 32'd0);
        check_eq("rst_err", {30'd0, err}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        boot     = 1'b0;
        instr    = 11'd0;
        tog      = 1'b0;
        m_active = 1'b0;
        m_half   = 1'b0;
        m_cnt    = '0;
        m_addr   = '0;
        m_err    = 2'b00;
        m_lo     = 10'd0;
        last_data = 20'd0;

        // Reset state
        idle(3);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("cpu_out_of_reset", {31'd0, cpu_reset_n}, 32'd1);
        idle(2);

        // Basic load of three words
        start_session(1'b0);
        send_word(10'h001, 10'h3FF);
        send_word(10'h155, 10'h2AA);
        send_word(10'h000, 10'h001);
        end_session(1'b0, 10'h000);
        idle(2);

        // Orphan low half
        start_session(1'b0);
        send_word(10'h0A0, 10'h0B0);
        send_word(10'h0C0, 10'h0D0);
        send_half(10'h0E0);
        idle(1);
        end_session(1'b0, 10'h000);
        idle(2);

        // Overflow: five words into a four-word RAM
        start_session(1'b0);
        send_word(10'h011, 10'h111);
        send_word(10'h022, 10'h222);
        send_word(10'h033, 10'h333);
        send_word(10'h044, 10'h044);
        send_word(10'h055, 10'h155);
        idle(2);
        check_eq("ovf_addr_hold", {30'd0, mem_addr}, 32'd3);
        check_eq("ovf_data_hold", {12'd0, mem_wdata}, {12'd0, last_data});
        end_session(1'b0, 10'h000);
        idle(2);

        // Toggle while idle: no write, results held
        send_half(10'h2A5);
        send_half(10'h15A);
        idle(3);
        check_eq("idle_count_hold", {29'd0, word_count}, 32'd4);
        check_eq("idle_err_hold", {30'd0, err}, 32'd2);

        // Toggle coincident with boot rise, high half coincident with boot fall
        start_session(1'b1);
        send_word(10'h3C3, 10'h0F0);
        send_word(10'h1E1, 10'h2D2);
        send_half(10'h123);
        idle(1);
        end_session(1'b1, 10'h321);
        idle(2);

        // Back-to-back halves on consecutive clocks
        start_session(1'b0);
        for (int i = 0; i < 8; i++) send_half(10'(37 * i + 5));
        idle(2);
        end_session(1'b0, 10'h000);
        idle(2);

        // Reset in the middle of a load, after a low half
        start_session(1'b0);
        send_half(10'h2F0);
        idle(1);
        @(negedge clk);
        rst_n    = 1'b0;
        boot     = 1'b0;
        m_active = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_values();
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("cpu_after_mid_reset", {31'd0, cpu_reset_n}, 32'd1);
        idle(2);

        // A fresh session starts again at address 0
        start_session(1'b0);
        send_word(10'h3AB, 10'h0CD);
        end_session(1'b0, 10'h000);

        idle(4);
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
